// File: rtl/rom_arbiter.sv
// rom_arbiter
//   Shares one 16-bit external ROM read port among three requesters: the
//   68k program fetch path, the tile ROM fetch path and the sprite ROM fetch
//   path. Each requester's address is mapped into one linear 24-bit word
//   space. Video fetches are 32 bits wide and are split into two 16-bit
//   beats. Arbitration uses fixed priority tile > spr > cpu. A skip counter
//   forces a cpu grant once video has won MAX_SKIP times in a row while the
//   cpu was waiting.
//
// Optional feature (compile-time macro ROM68K_CACHE_EN):
//   This adds a one-entry, two-word cpu cache. A cpu miss fetches the aligned
//   word pair. A later cpu request that hits the pair is acknowledged from
//   IDLE without touching memory. Without the macro, every cpu read is a
//   single-beat access.
//
// Ports:
//   clk_main              sole clock
//   nRESET                synchronous active-low reset
//   cpu_req/addr/ack/data  68k word read (18-bit word addr, 16-bit data)
//   tile_req/addr/ack/data tile ROM read (20-bit 32-bit-unit addr, 32-bit data)
//   spr_req/addr/ack/data  sprite ROM read (20-bit 32-bit-unit addr, 32-bit data)
//   mem_rd/addr           memory read strobe (held until mem_ready) + word address
//   mem_ready/data        one-cycle completion pulse + 16-bit read data
module rom_arbiter #(
  parameter logic [23:0] P68K_BASE = 24'h000000,
  parameter logic [23:0] TILE_BASE = 24'h200000,
  parameter logic [23:0] SPR_BASE  = 24'h400000,
  parameter int unsigned MAX_SKIP  = 2
) (
  input  logic        clk_main,
  input  logic        nRESET,
  input  logic        cpu_req,
  input  logic [17:0] cpu_addr,
  output logic        cpu_ack,
  output logic [15:0] cpu_data,
  input  logic        tile_req,
  input  logic [19:0] tile_addr,
  output logic        tile_ack,
  output logic [31:0] tile_data,
  input  logic        spr_req,
  input  logic [19:0] spr_addr,
  output logic        spr_ack,
  output logic [31:0] spr_data,
  output logic        mem_rd,
  output logic [23:0] mem_addr,
  input  logic        mem_ready,
  input  logic [15:0] mem_data
);

  localparam logic [3:0] SKIP_LIMIT = 4'(MAX_SKIP);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, ACK} state_t;
  typedef enum logic [1:0] {OWN_CPU, OWN_TILE, OWN_SPR} owner_t;

  state_t      state;
  owner_t      owner;
  logic        two_beat;
  logic [15:0] beat_lo;
  logic [3:0]  skip_cnt;
  logic        cpu_forced;
  logic        cpu_alone;
  logic        cache_hit;

  // Video addresses count 32-bit units; the first beat lands on the even word.
  function automatic logic [23:0] video_addr(input logic [23:0] base,
                                             input logic [19:0] addr);
    return base + {3'b000, addr, 1'b0};
  endfunction

`ifdef ROM68K_CACHE_EN
  logic        cache_vld;
  logic [16:0] cache_tag;
  logic [31:0] cache_line;
  logic        cpu_sel;

  assign cache_hit = cpu_req && cache_vld && (cache_tag == cpu_addr[17:1]);
`else
  assign cache_hit = 1'b0;
`endif

  // The cpu wins outright once it has been skipped MAX_SKIP times, or when
  // no video request competes.
  assign cpu_forced = cpu_req && (skip_cnt >= SKIP_LIMIT);
  assign cpu_alone  = cpu_req && !tile_req && !spr_req;

  always_ff @(posedge clk_main) begin
    if (!nRESET) begin
      state     <= IDLE;
      owner     <= OWN_CPU;
      two_beat  <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      beat_lo   <= '0;
      skip_cnt  <= '0;
      cpu_ack   <= 1'b0;
      tile_ack  <= 1'b0;
      spr_ack   <= 1'b0;
      cpu_data  <= '0;
      tile_data <= '0;
      spr_data  <= '0;
`ifdef ROM68K_CACHE_EN
      cache_vld <= 1'b0;
      cpu_sel   <= 1'b0;
`endif
    end else begin
      cpu_ack  <= 1'b0;
      tile_ack <= 1'b0;
      spr_ack  <= 1'b0;
      // A cpu that stops asking forfeits its accumulated skip credit.
      if (!cpu_req) skip_cnt <= '0;

      case (state)
        IDLE: begin
          if (cache_hit) begin
`ifdef ROM68K_CACHE_EN
            cpu_data <= cpu_addr[0] ? cache_line[31:16] : cache_line[15:0];
`endif
            cpu_ack  <= 1'b1;
            skip_cnt <= '0;
            state    <= ACK;
          end else if (cpu_forced || cpu_alone) begin
            owner    <= OWN_CPU;
            skip_cnt <= '0;
            mem_rd   <= 1'b1;
            state    <= BEAT0;
`ifdef ROM68K_CACHE_EN
            // A miss refills the aligned pair. The entry is invalid until
            // both beats have landed, so an aborted fill never hits.
            mem_addr  <= P68K_BASE + {6'b000000, cpu_addr[17:1], 1'b0};
            two_beat  <= 1'b1;
            cpu_sel   <= cpu_addr[0];
            cache_tag <= cpu_addr[17:1];
            cache_vld <= 1'b0;
`else
            mem_addr <= P68K_BASE + {6'b000000, cpu_addr};
            two_beat <= 1'b0;
`endif
          end else if (tile_req) begin
            owner    <= OWN_TILE;
            mem_addr <= video_addr(TILE_BASE, tile_addr);
            two_beat <= 1'b1;
            mem_rd   <= 1'b1;
            state    <= BEAT0;
            if (cpu_req && (skip_cnt < SKIP_LIMIT)) skip_cnt <= skip_cnt + 4'd1;
          end else if (spr_req) begin
            owner    <= OWN_SPR;
            mem_addr <= video_addr(SPR_BASE, spr_addr);
            two_beat <= 1'b1;
            mem_rd   <= 1'b1;
            state    <= BEAT0;
            if (cpu_req && (skip_cnt < SKIP_LIMIT)) skip_cnt <= skip_cnt + 4'd1;
          end
        end

        BEAT0: begin
          if (mem_ready) begin
            beat_lo <= mem_data;
            mem_rd  <= 1'b0;
            if (two_beat) begin
              mem_addr <= mem_addr + 24'd1;
              state    <= BEAT1;
            end else begin
              cpu_data <= mem_data;
              cpu_ack  <= 1'b1;
              state    <= ACK;
            end
          end
        end

        BEAT1: begin
          // One dead cycle with mem_rd low separates the two beats.
          if (!mem_rd) begin
            mem_rd <= 1'b1;
          end else if (mem_ready) begin
            mem_rd <= 1'b0;
            state  <= ACK;
            case (owner)
              OWN_TILE: begin
                tile_data <= {mem_data, beat_lo};
                tile_ack  <= 1'b1;
              end
              OWN_SPR: begin
                spr_data <= {mem_data, beat_lo};
                spr_ack  <= 1'b1;
              end
              default: begin
`ifdef ROM68K_CACHE_EN
                cache_line <= {mem_data, beat_lo};
                cache_vld  <= 1'b1;
                cpu_data   <= cpu_sel ? mem_data : beat_lo;
                cpu_ack    <= 1'b1;
`endif
              end
            endcase
          end
        end

        ACK: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
module tb_rom_arbiter;

  localparam logic [23:0] P68K_BASE = 24'h000000;
  localparam logic [23:0] TILE_BASE = 24'h200000;
  localparam logic [23:0] SPR_BASE  = 24'h400000;
  localparam int          MAX_SKIP  = 2;
`ifdef ROM68K_CACHE_EN
  localparam int CACHE = 1;
`else
  localparam int CACHE = 0;
`endif

  logic        clk_main = 1'b0;
  logic        nRESET;
  logic        cpu_req, tile_req, spr_req;
  logic [17:0] cpu_addr;
  logic [19:0] tile_addr, spr_addr;
  logic        cpu_ack, tile_ack, spr_ack;
  logic [15:0] cpu_data;
  logic [31:0] tile_data, spr_data;
  logic        mem_rd;
  logic [23:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_data;

  always #5 clk_main = ~clk_main;

  rom_arbiter #(
    .P68K_BASE(P68K_BASE), .TILE_BASE(TILE_BASE), .SPR_BASE(SPR_BASE),
    .MAX_SKIP(MAX_SKIP)
  ) dut (
    .clk_main(clk_main), .nRESET(nRESET),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
    .tile_req(tile_req), .tile_addr(tile_addr), .tile_ack(tile_ack), .tile_data(tile_data),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_ack(spr_ack), .spr_data(spr_data),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          lat_fixed = -1;
  bit          stale_req = 1'b0;
  int          n_acc = 0;
  logic [23:0] addr_log[$];
  int          ack_order[$];
  logic [15:0] ovr[logic [23:0]];
  int          l1, l2, l3;
  int          n;
  logic        flag;

  // Memory contents: explicit overrides, otherwise a fixed address hash.
  function automatic logic [15:0] memval(input logic [23:0] a);
    if (ovr.exists(a)) return ovr[a];
    return a[15:0] ^ {a[23:16], 8'hC3};
  endfunction

  // Reference: what a requester must receive for a given address.
  function automatic logic [31:0] exp_data(input int who, input logic [19:0] a);
    logic [23:0] w;
    if (who == 0) return {16'h0000, memval(P68K_BASE + {6'b000000, a[17:0]})};
    w = ((who == 1) ? TILE_BASE : SPR_BASE) + {3'b000, a, 1'b0};
    return {memval(w + 24'd1), memval(w)};
  endfunction

  function automatic logic [15:0] order_code();
    logic [15:0] c;
    c = '0;
    foreach (ack_order[i]) if (i < 4) c[i*4 +: 4] = 4'(ack_order[i] + 1);
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: logs each access start, answers after a latency.
  initial begin
    int cnt;
    cnt = -1;
    mem_ready = 1'b0;
    mem_data  = '0;
    forever begin
      @(negedge clk_main);
      mem_ready = 1'b0;
      if (!nRESET) begin
        cnt = -1;
      end else if (stale_req) begin
        mem_ready = 1'b1;
        mem_data  = 16'hDEAD;
        stale_req = 1'b0;
      end else if (mem_rd) begin
        if (cnt < 0) begin
          addr_log.push_back(mem_addr);
          n_acc++;
          cnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
        end
        if (cnt == 0) begin
          mem_ready = 1'b1;
          mem_data  = memval(mem_addr);
          cnt = -1;
        end else begin
          cnt--;
        end
      end
    end
  end

  // One requester transaction: raise req, wait (bounded) for ack, drop req
  // in the ack cycle, check the returned data. lat = cycles until ack.
  task automatic req_txn(input int who, input logic [19:0] a, output int lat);
    int   k;
    logic ok;
    string nm;
    nm = (who == 0) ? "cpu" : (who == 1) ? "tile" : "spr";
    case (who)
      0: begin cpu_addr = a[17:0]; cpu_req = 1'b1; end
      1: begin tile_addr = a; tile_req = 1'b1; end
      default: begin spr_addr = a; spr_req = 1'b1; end
    endcase
    k = 0;
    ok = 1'b0;
    while (!ok && k < 300) begin
      @(negedge clk_main);
      k++;
      ok = (who == 0) ? cpu_ack : (who == 1) ? tile_ack : spr_ack;
    end
    case (who)
      0: cpu_req = 1'b0;
      1: tile_req = 1'b0;
      default: spr_req = 1'b0;
    endcase
    lat = k;
    if (!ok) begin
      check({nm, " ack timeout"}, 64'(0), 64'(1));
    end else begin
      ack_order.push_back(who);
      if (who == 0)
        check({nm, " data"}, 64'(cpu_data), 64'(exp_data(0, a)));
      else if (who == 1)
        check({nm, " data"}, 64'(tile_data), 64'(exp_data(1, a)));
      else
        check({nm, " data"}, 64'(spr_data), 64'(exp_data(2, a)));
    end
  endtask

  initial begin
    nRESET = 1'b0;
    cpu_req = 1'b0; tile_req = 1'b0; spr_req = 1'b0;
    cpu_addr = 18'h11110; tile_addr = 20'h00005; spr_addr = 20'h00007;
    cpu_req = 1'b1; tile_req = 1'b1; spr_req = 1'b1;

    // Reset held with every request high
    repeat (3) begin
      @(negedge clk_main);
      check("reset ctrl", 64'({mem_rd, cpu_ack, tile_ack, spr_ack, mem_addr}), 64'(0));
      check("reset cpu/tile data", 64'({cpu_data, tile_data}), 64'(0));
      check("reset spr data", 64'(spr_data), 64'(0));
    end
    nRESET = 1'b1;
    @(negedge clk_main);
    check("release mem_rd", 64'(mem_rd), 64'(1));
    check("release mem_addr", 64'(mem_addr), 64'(TILE_BASE + 24'h00000A));
    ack_order.delete();
    fork
      req_txn(1, 20'h00005, l1);
      req_txn(2, 20'h00007, l2);
      req_txn(0, 20'h11110, l3);
    join
    check("release order", {48'(ack_order.size()), order_code()}, {48'd3, 16'h0132});

    // Single cpu read, memory answers 3 cycles into the access
    lat_fixed = 3;
    ovr[24'h000123] = 16'hBEEF;
    @(negedge clk_main);
    addr_log.delete(); n_acc = 0;
    req_txn(0, 20'h00123, l1);
    check("cpu single value", 64'(cpu_data), 64'(16'hBEEF));
    @(negedge clk_main);
    check("cpu ack one pulse", 64'(cpu_ack), 64'(0));
    if (CACHE != 0) begin
      check("cpu miss beats", 64'(n_acc), 64'(2));
      check("cpu miss addr0", 64'(addr_log[0]), 64'(24'h000122));
    end else begin
      check("cpu beats", 64'(n_acc), 64'(1));
      check("cpu addr", 64'(addr_log[0]), 64'(24'h000123));
    end

    // 32-bit sprite fetch
    lat_fixed = 1;
    ovr[24'h400020] = 16'h1111;
    ovr[24'h400021] = 16'h2222;
    @(negedge clk_main);
    addr_log.delete(); n_acc = 0;
    req_txn(2, 20'h00010, l1);
    check("spr 32-bit value", 64'(spr_data), 64'(32'h22221111));
    check("spr beats", 64'(n_acc), 64'(2));
    check("spr beat0 addr", 64'(addr_log[0]), 64'(24'h400020));
    check("spr beat1 addr", 64'(addr_log[1]), 64'(24'h400021));

    // Minimum latencies with zero-wait memory
    lat_fixed = 0;
    @(negedge clk_main);
    req_txn(0, 20'h01000, l1);
    check("cpu min latency", 64'(l1), 64'((CACHE != 0) ? 4 : 2));
    @(negedge clk_main);
    req_txn(1, 20'h0F00D, l1);
    check("tile min latency", 64'(l1), 64'(4));

    // Contention: all three together
    lat_fixed = -1;
    @(negedge clk_main);
    ack_order.delete();
    fork
      req_txn(0, 20'h2A000, l1);
      req_txn(1, 20'h12345, l2);
      req_txn(2, 20'h54321, l3);
    join
    check("contention order", {48'(ack_order.size()), order_code()}, {48'd3, 16'h0132});

    // Starvation guard: tile keeps coming back while cpu waits
    @(negedge clk_main);
    ack_order.delete();
    fork
      req_txn(0, 20'h2B000, l1);
      begin
        repeat (3) req_txn(1, 20'($urandom), l2);
      end
    join
    check("starvation order", {48'(ack_order.size()), order_code()}, {48'd4, 16'h2122});

    // Repeat read of a neighbouring word, then after reset
    lat_fixed = 1;
    @(negedge clk_main);
    n_acc = 0;
    req_txn(0, 20'h00040, l1);
    check("pair read beats", 64'(n_acc), 64'((CACHE != 0) ? 2 : 1));
    @(negedge clk_main);
    n_acc = 0;
    req_txn(0, 20'h00041, l1);
    check("neighbour beats", 64'(n_acc), 64'((CACHE != 0) ? 0 : 1));
    if (CACHE != 0) check("hit latency", 64'(l1), 64'(1));
    @(negedge clk_main);
    nRESET = 1'b0;
    @(negedge clk_main);
    nRESET = 1'b1;
    @(negedge clk_main);
    n_acc = 0;
    req_txn(0, 20'h00041, l1);
    check("post-reset beats", 64'(n_acc), 64'((CACHE != 0) ? 2 : 1));

    // Reset in the middle of a beat, then a stale mem_ready
    lat_fixed = 20;
    @(negedge clk_main);
    tile_addr = 20'h00ABC;
    tile_req = 1'b1;
    n = 0;
    while (!mem_rd && n < 20) begin
      @(negedge clk_main);
      n++;
    end
    check("midreset access started", 64'(mem_rd), 64'(1));
    repeat (2) @(negedge clk_main);
    nRESET = 1'b0;
    tile_req = 1'b0;
    @(negedge clk_main);
    check("midreset abort", 64'({mem_rd, cpu_ack, tile_ack, spr_ack}), 64'(0));
    check("midreset tile data", 64'(tile_data), 64'(0));
    nRESET = 1'b1;
    stale_req = 1'b1;
    flag = 1'b0;
    repeat (4) begin
      @(negedge clk_main);
      flag = flag | cpu_ack | tile_ack | spr_ack | mem_rd;
    end
    check("stale ready ignored", 64'(flag), 64'(0));

    // Randomised concurrent traffic
    lat_fixed = -1;
    fork
      begin
        int lc;
        repeat (15) begin
          repeat ($urandom_range(0, 3)) @(negedge clk_main);
          req_txn(0, 20'h30000 + 20'($urandom_range(0, 15)), lc);
        end
      end
      begin
        int lt;
        repeat (15) begin
          repeat ($urandom_range(0, 3)) @(negedge clk_main);
          req_txn(1, 20'($urandom), lt);
        end
      end
      begin
        int ls;
        repeat (15) begin
          repeat ($urandom_range(0, 3)) @(negedge clk_main);
          req_txn(2, 20'($urandom), ls);
        end
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
